// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler in front of a UART transmit core, with idle gap bits after each frame.
// Optional UART_SCHED_BURST_EN lets one grant send up to BURST_MAX back-to-back bytes.
module uart_tx_sched #(
  parameter int N_REQ     = 4,
  parameter int BIT_CLKS  = 1087,
  parameter int GAP_BITS  = 3,
  parameter int BURST_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     sched_busy
);

  localparam int GW      = $clog2(N_REQ);
  localparam int GAP_CYC = GAP_BITS * BIT_CLKS;
  localparam int CW      = $clog2(15 * BIT_CLKS + 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP} state_t;

  state_t        state, state_nx;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] pick;
  logic          pick_ok;
  logic [CW-1:0] gap_cnt;
  logic          burst_more;
  logic [7:0]    req_byte [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_byte[i] = req_data[8*i +: 8];
  end

  // Nearest valid requester after last_grant wins; the k=1 candidate is evaluated last.
  always_comb begin
    logic [GW-1:0] idx;
    idx     = '0;
    pick    = last_grant;
    pick_ok = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % N_REQ);
      if (req_valid[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

`ifdef UART_SCHED_BURST_EN
  localparam int BW = $clog2(BURST_MAX + 1);
  logic [BW-1:0] burst_cnt;

  assign burst_more = req_valid[grant_id] && (burst_cnt < BW'(BURST_MAX));

  // Bytes sent under the current grant, including the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (state == IDLE && state_nx == ISSUE) begin
      burst_cnt <= BW'(1);
    end else if (state == WAIT_DONE && state_nx == ISSUE) begin
      burst_cnt <= burst_cnt + BW'(1);
    end
  end
`else
  logic cfg_unused;
  assign burst_more = 1'b0;
  // Keeps BURST_MAX referenced when bursts are compiled out.
  assign cfg_unused = (BURST_MAX > 0);
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (!tx_busy && pick_ok) state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_ACK;
      WAIT_ACK:  if (tx_busy) state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (burst_more)        state_nx = ISSUE;
          else if (GAP_CYC == 0) state_nx = IDLE;
          else                   state_nx = GAP;
        end
      end
      GAP:       if (gap_cnt == GAP_LAST) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  assign tx_start   = (state == ISSUE);
  assign req_ready  = tx_start ? (N_REQ'(1) << grant_id) : '0;
  assign sched_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      tx_data    <= 8'h00;
      last_grant <= GW'(N_REQ - 1);
      gap_cnt    <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= (state == GAP && state_nx == GAP) ? gap_cnt + CW'(1) : '0;
      if (state == IDLE && state_nx == ISSUE) begin
        grant_id <= pick;
        tx_data  <= req_byte[pick];
`ifndef UART_SCHED_BURST_EN
        last_grant <= pick;
`endif
      end
`ifdef UART_SCHED_BURST_EN
      // Rotation only advances once the grantee's burst is over.
      if (state == WAIT_DONE && state_nx == ISSUE) begin
        tx_data <= req_byte[grant_id];
      end
      if (state == WAIT_DONE && !tx_busy && state_nx != ISSUE) begin
        last_grant <= grant_id;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queued requesters, a frame-length core model and a round-robin reference model.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int GW = 2;
  localparam int BC = 8;
  localparam int GB = 3;
  localparam int BM = 4;
  localparam int F  = 10 * BC;
  localparam int G  = GB * BC;
`ifdef UART_SCHED_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, req_valid0, req_ready0;
  logic [8*N-1:0] req_data, req_data0;
  logic           tx_start, tx_start0, tx_busy, tx_busy0, sched_busy, sched_busy0;
  logic [7:0]     tx_data, tx_data0;
  logic [GW-1:0]  grant_id, grant_id0;

  uart_tx_sched #(.N_REQ(N), .BIT_CLKS(BC), .GAP_BITS(GB), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
    .sched_busy(sched_busy)
  );

  uart_tx_sched #(.N_REQ(N), .BIT_CLKS(BC), .GAP_BITS(0), .BURST_MAX(BM)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data0), .req_ready(req_ready0),
    .tx_start(tx_start0), .tx_data(tx_data0), .tx_busy(tx_busy0), .grant_id(grant_id0),
    .sched_busy(sched_busy0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [GW-1:0] gid;
    logic [7:0]    data;
    logic [N-1:0]  rdy;
    logic          sbusy;
  } ev_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [7:0]  rqa [N][$];
  logic [7:0]  rqb [N][$];
  int          cnt_a = 0, cnt_b = 0;
  bit          hold_busy = 0;
  int          fall_a = 0;
  int          falls_b[$];
  int          stray_a = 0;
  ev_t         ev_a[$], ev_b[$];
  logic [31:0] exp_q[$];
  int          mdl_last = N - 1;
  bit          timed_out;

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = rqa[i].size() > 0;
      req_data[8*i +: 8]  = (rqa[i].size() > 0) ? rqa[i][0] : 8'h00;
      req_valid0[i]       = rqb[i].size() > 0;
      req_data0[8*i +: 8] = (rqb[i].size() > 0) ? rqb[i][0] : 8'h00;
    end
  endtask

  // One clock: observe outputs at the falling edge, then advance requesters and core models.
  task automatic step();
    ev_t e;
    bit  prev;
    @(negedge clk);
    cyc++;
    if (tx_start) begin
      e.cyc = cyc; e.gid = grant_id; e.data = tx_data; e.rdy = req_ready; e.sbusy = sched_busy;
      ev_a.push_back(e);
    end
    if (tx_start0) begin
      e.cyc = cyc; e.gid = grant_id0; e.data = tx_data0; e.rdy = req_ready0; e.sbusy = sched_busy0;
      ev_b.push_back(e);
    end
    if (req_ready != '0 && !tx_start) stray_a++;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && rqa[i].size() > 0) void'(rqa[i].pop_front());
      if (req_ready0[i] && rqb[i].size() > 0) void'(rqb[i].pop_front());
    end
    // Core: busy for F sampled edges starting with the edge that ends the tx_start cycle.
    prev = tx_busy;
    if (tx_start) cnt_a = F; else if (cnt_a > 0) cnt_a--;
    tx_busy = hold_busy || (cnt_a > 0);
    if (prev && !tx_busy) fall_a = cyc;
    prev = tx_busy0;
    if (tx_start0) cnt_b = F; else if (cnt_b > 0) cnt_b--;
    tx_busy0 = (cnt_b > 0);
    if (prev && !tx_busy0) falls_b.push_back(cyc);
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rqa[i].size() > 0 || rqb[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    timed_out = 1'b0;
    step();
    while (!(all_empty() && cnt_a == 0 && cnt_b == 0 && !sched_busy && !sched_busy0)) begin
      if (n >= budget) begin
        timed_out = 1'b1;
        break;
      end
      step();
      n++;
    end
  endtask

  // ---------------- reference model ----------------
  // Entry = {cycles since previous frame start (or since run start), grant, byte}.
  task automatic build_expect();
    logic [7:0] mq [N][$];
    int pick, n, sp;
    for (int i = 0; i < N; i++) mq[i] = rqa[i];
    exp_q.delete();
    sp = 1;
    forever begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && mq[(mdl_last + k) % N].size() > 0) pick = (mdl_last + k) % N;
      if (pick < 0) break;
      n = 0;
      do begin
        exp_q.push_back({16'(sp), 8'(pick), mq[pick].pop_front()});
        n++;
        sp = F + 1;
      end while (BURST && mq[pick].size() > 0 && n < BM);
      // frame, gap, one arbitration cycle in IDLE, then the ISSUE cycle
      sp = F + G + 2;
      mdl_last = pick;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tx_busy = 1'b0; tx_busy0 = 1'b0; hold_busy = 1'b0; cnt_a = 0; cnt_b = 0;
    drive();
    repeat (3) @(negedge clk);
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", tx_data); end
    total++; if (grant_id !== '0) begin bad++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", sched_busy); end
    rst = 1'b0;
    mdl_last = N - 1;
  endtask

  task automatic test_first_grant();
    int start;
    ev_a.delete();
    rqa[0].push_back(8'h41);
    start = cyc + 1;
    run_until_idle(2000);
    total++; if (timed_out) begin bad++; $display("FAIL first_timeout: got timeout want idle"); end
    total++;
    if (ev_a.size() !== 1) begin
      bad++; $display("FAIL first_count: got %0d want 1", ev_a.size());
    end else begin
      total++; if (ev_a[0].cyc !== start + 1) begin bad++; $display("FAIL first_latency: got %0d want %0d", ev_a[0].cyc, start + 1); end
      total++; if (ev_a[0].data !== 8'h41) begin bad++; $display("FAIL first_data: got %h want 41", ev_a[0].data); end
      total++; if (ev_a[0].rdy !== 4'b0001) begin bad++; $display("FAIL first_ready: got %b want 0001", ev_a[0].rdy); end
      total++; if (ev_a[0].gid !== 2'd0) begin bad++; $display("FAIL first_gid: got %0d want 0", ev_a[0].gid); end
      total++; if (ev_a[0].sbusy !== 1'b1) begin bad++; $display("FAIL first_sbusy: got %b want 1", ev_a[0].sbusy); end
    end
    mdl_last = 0;
  endtask

  task automatic test_round_robin();
    int prev, nexp;
    logic [31:0] e;
    rst = 1'b1; step(); rst = 1'b0; mdl_last = N - 1;
    for (int round = 0; round < 5; round++) begin
      for (int i = 0; i < N; i++) begin
        int cnt;
        cnt = (round == 0) ? 2 : $urandom_range(0, 3);
        for (int b = 0; b < cnt; b++) rqa[i].push_back(8'($urandom_range(0, 255)));
      end
      ev_a.delete();
      stray_a = 0;
      build_expect();
      nexp = exp_q.size();
      prev = cyc + 1;
      run_until_idle(nexp * (F + G + 10) + 100);
      total++; if (timed_out) begin bad++; $display("FAIL rr_timeout: round %0d got timeout want idle", round); end
      total++; if (ev_a.size() !== nexp) begin bad++; $display("FAIL rr_count: round %0d got %0d want %0d", round, ev_a.size(), nexp); end
      for (int j = 0; j < nexp && j < ev_a.size(); j++) begin
        e = exp_q[j];
        total++; if (ev_a[j].gid !== e[9:8]) begin bad++; $display("FAIL rr_gid: round %0d frame %0d got %0d want %0d", round, j, ev_a[j].gid, e[9:8]); end
        total++; if (ev_a[j].data !== e[7:0]) begin bad++; $display("FAIL rr_data: round %0d frame %0d got %h want %h", round, j, ev_a[j].data, e[7:0]); end
        total++; if (ev_a[j].rdy !== (N'(1) << e[9:8])) begin bad++; $display("FAIL rr_ready: round %0d frame %0d got %b want %b", round, j, ev_a[j].rdy, N'(1) << e[9:8]); end
        total++; if (ev_a[j].cyc - prev !== int'(e[31:16])) begin bad++; $display("FAIL rr_spacing: round %0d frame %0d got %0d want %0d", round, j, ev_a[j].cyc - prev, e[31:16]); end
        prev = ev_a[j].cyc;
      end
      total++; if (stray_a !== 0) begin bad++; $display("FAIL rr_stray_ready: round %0d got %0d want 0", round, stray_a); end
    end
  endtask

  task automatic test_busy_hold();
    logic [7:0] b;
    int rel, n;
    rst = 1'b1; hold_busy = 1'b1; step();
    b = 8'($urandom_range(0, 255));
    rqa[1].push_back(b);
    step(); rst = 1'b0; mdl_last = N - 1;
    ev_a.delete();
    repeat (40) step();
    total++; if (ev_a.size() !== 0) begin bad++; $display("FAIL hold_no_start: got %0d starts want 0", ev_a.size()); end
    hold_busy = 1'b0;
    rel = cyc + 1;
    n = 0;
    while (ev_a.size() == 0 && n < 100) begin step(); n++; end
    total++;
    if (ev_a.size() !== 1) begin
      bad++; $display("FAIL hold_count: got %0d want 1", ev_a.size());
    end else begin
      total++; if (ev_a[0].cyc !== rel + 1) begin bad++; $display("FAIL hold_latency: got %0d want %0d", ev_a[0].cyc, rel + 1); end
      total++; if (ev_a[0].gid !== 2'd1) begin bad++; $display("FAIL hold_gid: got %0d want 1", ev_a[0].gid); end
      total++; if (ev_a[0].data !== b) begin bad++; $display("FAIL hold_data: got %h want %h", ev_a[0].data, b); end
    end
    run_until_idle(2000);
    mdl_last = 1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] c;
    int n;
    ev_a.delete();
    rqa[0].push_back(8'($urandom_range(0, 255)));
    n = 0;
    while (ev_a.size() == 0 && n < 100) begin step(); n++; end
    repeat (10) step();
    total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", sched_busy); end
    #2 rst = 1'b1;
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL mid_ready: got %b want 0", req_ready); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_start: got %b want 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_data: got %h want 00", tx_data); end
    total++; if (grant_id !== '0) begin bad++; $display("FAIL mid_gid: got %0d want 0", grant_id); end
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL mid_sbusy: got %b want 0", sched_busy); end
    step(); rst = 1'b0; mdl_last = N - 1;
    c = 8'($urandom_range(0, 255));
    rqa[2].push_back(c);
    ev_a.delete();
    n = 0;
    while (ev_a.size() == 0 && n < 400) begin step(); n++; end
    total++;
    if (ev_a.size() !== 1) begin
      bad++; $display("FAIL mid_count: got %0d want 1", ev_a.size());
    end else begin
      total++; if (ev_a[0].cyc !== fall_a + 1) begin bad++; $display("FAIL mid_wait_idle: got %0d want %0d", ev_a[0].cyc, fall_a + 1); end
      total++; if (ev_a[0].gid !== 2'd2) begin bad++; $display("FAIL mid_gid2: got %0d want 2", ev_a[0].gid); end
      total++; if (ev_a[0].data !== c) begin bad++; $display("FAIL mid_data2: got %h want %h", ev_a[0].data, c); end
    end
    run_until_idle(2000);
    mdl_last = 2;
  endtask

  task automatic test_gap0();
    int start;
    ev_b.delete();
    falls_b.delete();
    rqb[2].push_back(8'h44);
    rqb[2].push_back(8'h45);
    start = cyc + 1;
    run_until_idle(2000);
    total++; if (timed_out) begin bad++; $display("FAIL gap0_timeout: got timeout want idle"); end
    total++;
    if (ev_b.size() !== 2 || falls_b.size() < 1) begin
      bad++; $display("FAIL gap0_count: got %0d starts want 2", ev_b.size());
    end else begin
      total++; if (ev_b[0].cyc !== start + 1) begin bad++; $display("FAIL gap0_first: got %0d want %0d", ev_b[0].cyc, start + 1); end
      total++; if (ev_b[0].data !== 8'h44) begin bad++; $display("FAIL gap0_data0: got %h want 44", ev_b[0].data); end
      total++; if (ev_b[1].data !== 8'h45) begin bad++; $display("FAIL gap0_data1: got %h want 45", ev_b[1].data); end
      total++; if (ev_b[1].gid !== 2'd2) begin bad++; $display("FAIL gap0_gid: got %0d want 2", ev_b[1].gid); end
      total++; if (ev_b[1].cyc !== falls_b[0] + (BURST ? 1 : 2)) begin bad++; $display("FAIL gap0_second: got %0d want %0d", ev_b[1].cyc, falls_b[0] + (BURST ? 1 : 2)); end
    end
  endtask

`ifdef UART_SCHED_BURST_EN
  task automatic test_burst();
    int prev, nexp;
    logic [31:0] e;
    rst = 1'b1; step(); rst = 1'b0; mdl_last = N - 1;
    for (int b = 0; b < 5; b++) begin
      rqa[1].push_back(8'($urandom_range(0, 255)));
      rqa[3].push_back(8'($urandom_range(0, 255)));
    end
    ev_a.delete();
    build_expect();
    nexp = exp_q.size();
    prev = cyc + 1;
    run_until_idle(nexp * (F + G + 10) + 100);
    total++; if (ev_a.size() !== nexp) begin bad++; $display("FAIL burst_count: got %0d want %0d", ev_a.size(), nexp); end
    for (int j = 0; j < nexp && j < ev_a.size(); j++) begin
      e = exp_q[j];
      total++; if (ev_a[j].gid !== e[9:8]) begin bad++; $display("FAIL burst_gid: frame %0d got %0d want %0d", j, ev_a[j].gid, e[9:8]); end
      total++; if (ev_a[j].data !== e[7:0]) begin bad++; $display("FAIL burst_data: frame %0d got %h want %h", j, ev_a[j].data, e[7:0]); end
      total++; if (ev_a[j].cyc - prev !== int'(e[31:16])) begin bad++; $display("FAIL burst_spacing: frame %0d got %0d want %0d", j, ev_a[j].cyc - prev, e[31:16]); end
      prev = ev_a[j].cyc;
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_busy_hold();
    test_reset_mid();
    test_gap0();
`ifdef UART_SCHED_BURST_EN
    test_burst();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of byte requesters, range 2..8.
REQ-002 SHALL have parameter BIT_CLKS, default 1087: clk cycles per UART bit period.
REQ-003 SHALL have parameter GAP_BITS, default 3: idle bit periods inserted after each frame, range 0..15.
REQ-004 SHALL have parameter BURST_MAX, default 4: maximum bytes per grant when UART_SCHED_BURST_EN is defined.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester byte available.
REQ-008 SHALL have port req_data  input  8*N_REQ  byte of requester i in bits [8i+7:8i].
REQ-009 SHALL have port req_ready  output  N_REQ  one-hot, one-cycle byte-accept pulse.
REQ-010 SHALL have port tx_start  output  1  one-cycle frame-start pulse to the UART transmit core.
REQ-011 SHALL have port tx_data  output  8  byte presented to the core, stable from tx_start until the next ISSUE.
REQ-012 SHALL have port tx_busy  input  1  core frame-in-progress flag.
REQ-013 SHALL have port grant_id  output  clog2(N_REQ)  index of the current or last granted requester.
REQ-014 SHALL have port sched_busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP.
REQ-016 In IDLE with tx_busy=0 and any req_valid high, the block SHALL move to ISSUE on that edge, latch grant_id, and load tx_data from req_data[grant_id].
REQ-017 In IDLE with tx_busy=1, the block SHALL NOT grant.
REQ-018 Grant SHALL be round-robin: search starts at last_grant+1 and wraps modulo N_REQ; last_grant resets to N_REQ-1, so requester 0 has first priority after reset.
REQ-019 ISSUE SHALL last exactly one cycle with req_ready[grant_id]=1 and tx_start=1; all other req_ready bits SHALL be 0.
REQ-020 tx_start SHALL assert on the first cycle after the IDLE edge that sampled a valid request (latency 1).
REQ-021 The captured byte SHALL be transmitted even if req_valid drops during ISSUE; requesters must hold data stable until ready.
REQ-022 WAIT_ACK SHALL wait for tx_busy=1, then enter WAIT_DONE.
REQ-023 WAIT_DONE SHALL wait for tx_busy=0, then enter GAP; if GAP_BITS=0 it SHALL enter IDLE instead.
REQ-024 GAP SHALL count exactly GAP_BITS*BIT_CLKS cycles, then enter IDLE; the counter SHALL be wide enough for 15*BIT_CLKS.
REQ-025 Requests arriving outside IDLE SHALL be held pending, with no ready pulse, until the next arbitration.
REQ-026 Simultaneous valid and grant: only the grantee SHALL see ready; the others keep valid and are served in rotation order.

Reset
REQ-027 On rst=1, state SHALL become IDLE immediately, and the following SHALL reset: req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, sched_busy=0, last_grant=N_REQ-1, gap counter=0, burst counter=0.
REQ-028 Reset mid-frame SHALL abandon tracking; after release, the block SHALL wait for tx_busy=0 per REQ-017.

Configuration
REQ-029 Macro UART_SCHED_BURST_EN defined: in WAIT_DONE, when tx_busy falls, if req_valid[grant_id]=1 and bytes sent in this grant < BURST_MAX, the block SHALL go directly to ISSUE for the same requester, skipping GAP; last_grant SHALL update only when the burst ends.
REQ-030 UART_SCHED_BURST_EN undefined: each byte SHALL be individually arbitrated and followed by GAP; no burst counter SHALL exist.

Verification
REQ-031 Reset, then req_valid=4'b0001 with data 8'h41 -> one-cycle tx_start one cycle later, tx_data=8'h41, req_ready=4'b0001, grant_id=0.
REQ-032 req_valid=4'b1111 held, core model busy for 10 bit periods -> grants 0,1,2,3,0 in order, each frame separated by exactly 3*1087 idle cycles.
REQ-033 tx_busy held high at reset release with req_valid=4'b0010 -> no tx_start until tx_busy falls.
REQ-034 rst pulsed during WAIT_DONE -> all outputs at reset values in the same cycle, sched_busy=0.
REQ-035 GAP_BITS=0, requester 2 valid for bytes 8'h44 then 8'h45 -> second tx_start on the cycle after tx_busy falls plus 1.
REQ-036 UART_SCHED_BURST_EN, BURST_MAX=4, requesters 1 and 3 continuously valid -> 4 bytes from 1 without gaps, then GAP, then 4 bytes from 3.
